pixel_scan_engine: RTL and testbench
====================================

# pixel_scan_engine

Parametrised pixel scan source and result sink for the Lab image pipeline, running entirely on `clk50`. It generates a pixel strobe, column and row counters, active-area flags and linear read addresses for the pixel memory, for any active and blanking geometry. It supports single-frame and continuous operation, and a stop request that only takes effect at a frame boundary. Optionally it computes a per-frame checksum of the RGB results returned by the processing core, so frame-level self-checking works without dumping every pixel.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BLANK`, 160: blanking pixels per line. Minimum 0.
- `V_BLANK`, 45: blanking lines per frame. Minimum 0.
- `PIX_DIV`, 2: `clk50` cycles per pixel. Minimum 1.
- `CNT_W`, 12: width of the column and row counters.
- `ADDR_W`, 20: width of the linear address.
- `LAT`, 2: cycles from `mem_rd` to valid RGB input. Minimum 1.
- `clk50` in 1: system clock. Every register is clocked on its rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `start` in 1: begin scanning. Sampled in IDLE only.
- `continuous` in 1: sampled at every frame end. 1 = run the next frame.
- `stop` in 1: request to stop. Takes effect at the end of the current frame.
- `busy` out 1: high while not in IDLE.
- `pixel_ce` out 1: one-cycle pixel strobe.
- `Pixel_Col_cnt` out CNT_W: current column.
- `Pixel_Row_cnt` out CNT_W: current row.
- `active` out 1: current pixel is inside the active area.
- `sof` out 1: start of frame. Equals `pixel_ce` at (0,0).
- `eof` out 1: end of frame. Equals `pixel_ce` at (H_TOTAL-1, V_TOTAL-1).
- `mem_addr` out ADDR_W: linear active-pixel address.
- `mem_rd` out 1: read strobe. Equals `pixel_ce & active`.
- `frame_cnt` out 16: number of completed frames. Wraps.
- `RM_data`, `GM_data`, `BM_data` in 8 each: processed pixel returned by the core.
- `checksum` out 32: per-frame checksum.
- `checksum_valid` out 1: one-cycle pulse when `checksum` is updated.

## Operation
- H_TOTAL = H_ACTIVE + H_BLANK; V_TOTAL = V_ACTIVE + V_BLANK.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Counters, divider and `mem_addr` are held at 0.
  - `start` = 1 → RUN. `stop_pending` is cleared on entry.
- RUN:
  - The divider counts 0 → PIX_DIV-1.
  - `pixel_ce` is high while the divider equals PIX_DIV-1. The divider then wraps to 0.
- Counter advance on `pixel_ce`:
  - Column increments.
  - At H_TOTAL-1 the column wraps to 0 and the row increments.
  - At V_TOTAL-1 the row wraps to 0.
- `active` = (col < H_ACTIVE) && (row < V_ACTIVE).
- `mem_addr`:
  - Increments on every `mem_rd`.
  - Returns to 0 when the counters wrap to (0,0).
  - It therefore equals row*H_ACTIVE + col for the active pixel being read.
- On `eof`:
  - `frame_cnt` increments.
  - If `continuous` = 1 and `stop_pending` = 0, scanning continues at (0,0) with no gap.
  - Otherwise → DRAIN.
- `stop`:
  - Sets `stop_pending` at any cycle in RUN.
  - A frame is never truncated.
- DRAIN:
  - Lasts exactly LAT cycles, then → IDLE.
  - Counters read 0 and `pixel_ce` = 0 throughout.
- `start` while `busy` = 1 is ignored.
- Reset values: every output 0. `stop_pending` = 0. State IDLE.
- Reset asserted mid-frame aborts the frame. Outputs are 0 after that edge and no `checksum_valid` is issued.

## Timing
- `start` high at edge k → `busy` = 1 after edge k.
- The first `pixel_ce` is high during cycle k+PIX_DIV, that is PIX_DIV cycles after RUN entry.
- Counters, `mem_addr` and `frame_cnt` update on the edge that samples `pixel_ce`.
- `active`, `sof`, `eof` and `mem_rd` describe the current counter values during the strobe cycle.
- One frame occupies H_TOTAL × V_TOTAL × PIX_DIV cycles in RUN.
- With PIX_DIV = 1, `pixel_ce` is held high continuously in RUN.
- Return path: RGB data is valid on the cycle LAT cycles after `mem_rd`. `mem_rd`, `sof` and `eof` are delayed by an LAT-stage shift register (`rd_d`, `sof_d`, `eof_d`).
- `checksum_valid` fires on the `eof_d` cycle.
- `busy` falls on the edge after that cycle when the engine is stopping.

## Configuration
- `PIXEL_SCAN_CHECKSUM_EN` defined:
  - Sample word S = {RM_data, GM_data, BM_data}, 24 bits, zero-extended to 32.
  - On `rd_d` with `sof_d`: sum = S.
  - On `rd_d` otherwise: sum += S, modulo 2^32.
  - On `eof_d`: `checksum` ← final sum, including S if `rd_d` is also high. `checksum_valid` = 1 for one cycle.
  - The sum is held at its last value between frames.
  - In continuous mode, frame N+1's `sof_d` arrives after frame N's `eof_d`, so frames never mix.
- Not defined:
  - `checksum` and `checksum_valid` are tied to 0 and the RGB inputs are unused.
  - DRAIN is skipped: `eof` with stop goes straight to IDLE.

## Test plan
Bench parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=1, PIX_DIV=2, LAT=2. The bench drives BM_data = `mem_addr` delayed 2 cycles and RM/GM = 0.
- Reset, then `start` pulse with `continuous` = 0:
  - 18 `pixel_ce`, 36 RUN cycles.
  - 8 `mem_rd` with addresses 0..7.
  - `frame_cnt` = 1; `busy` = 0 after DRAIN.
- Same run with the macro defined → one `checksum_valid` with `checksum` = 0x0000001C.
- `continuous` = 1 for 3 frames, then `stop` mid-frame 3:
  - Frame 3 completes.
  - `frame_cnt` = 3; three `checksum_valid` pulses, each 0x1C.
  - `sof` is spaced exactly 36 cycles apart.
- `start` re-pulsed while `busy` → no effect on counters or timing.
- `rst_n` = 0 at row 1, col 2 → all outputs 0 next edge, no `checksum_valid`. A following `start` produces a clean frame with address 0 first.
- PIX_DIV=1, H_BLANK=0, V_BLANK=0:
  - `pixel_ce` high continuously.
  - `eof` coincides with `mem_rd` at address 7; checksum = 0x1C.

Source files
------------

// File: rtl/pixel_scan_engine.sv
// pixel_scan_engine
// Pixel scan source and result sink for the Lab image pipeline, single clock
// domain (clk50). Produces a divided pixel strobe, column/row counters,
// active-area and frame flags, and linear read addresses for the pixel
// memory. Supports single-frame and continuous scanning; a stop request is
// honoured only at the end of the current frame.
//
// Optional feature, macro PIXEL_SCAN_CHECKSUM_EN: a per-frame 32-bit sum of
// the RGB words returned by the processing core LAT cycles after each read,
// plus a DRAIN state that waits for the last returned pixel.
//
// Ports:
//   clk50, rst_n (synchronous, active-low)
//   start, continuous, stop            control inputs
//   busy                               high while not IDLE
//   pixel_ce, Pixel_Col_cnt, Pixel_Row_cnt, active, sof, eof
//   mem_addr, mem_rd                   pixel memory read port
//   frame_cnt                          completed frames (wraps)
//   RM_data, GM_data, BM_data          processed pixel from the core
//   checksum, checksum_valid           per-frame sum and update pulse
module pixel_scan_engine #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int V_BLANK  = 45,
    parameter int PIX_DIV  = 2,
    parameter int CNT_W    = 12,
    parameter int ADDR_W   = 20,
    parameter int LAT      = 2
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    output logic              busy,
    output logic              pixel_ce,
    output logic [CNT_W-1:0]  Pixel_Col_cnt,
    output logic [CNT_W-1:0]  Pixel_Row_cnt,
    output logic              active,
    output logic              sof,
    output logic              eof,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [15:0]       frame_cnt,
    input  logic [7:0]        RM_data,
    input  logic [7:0]        GM_data,
    input  logic [7:0]        BM_data,
    output logic [31:0]       checksum,
    output logic              checksum_valid
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    // A one-bit divider is kept even for PIX_DIV = 1 so the compare is legal.
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

`ifdef PIXEL_SCAN_CHECKSUM_EN
    localparam state_e ST_STOP = ST_DRAIN;
`else
    localparam state_e ST_STOP = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       frame_q, frame_d;
    logic              stop_pend_q, stop_pend_d;

    logic ce_s, col_last_s, row_last_s, active_s, sof_s, eof_s, rd_s;

    // Strobe and position decode from the current registered state.
    assign ce_s       = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign col_last_s = (col_q == COL_LAST);
    assign row_last_s = (row_q == ROW_LAST);
    assign active_s   = (state_q == ST_RUN) && (col_q < H_ACT_C) && (row_q < V_ACT_C);
    assign sof_s      = ce_s && (col_q == {CNT_W{1'b0}}) && (row_q == {CNT_W{1'b0}});
    assign eof_s      = ce_s && col_last_s && row_last_s;
    assign rd_s       = ce_s && active_s;

    assign busy          = (state_q != ST_IDLE);
    assign pixel_ce      = ce_s;
    assign Pixel_Col_cnt = col_q;
    assign Pixel_Row_cnt = row_q;
    assign active        = active_s;
    assign sof           = sof_s;
    assign eof           = eof_s;
    assign mem_addr      = addr_q;
    assign mem_rd        = rd_s;
    assign frame_cnt     = frame_q;

`ifdef PIXEL_SCAN_CHECKSUM_EN
    localparam int DRN_W = $clog2(LAT + 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT - 1);
    logic [DRN_W-1:0] drain_q, drain_d;
    logic             drain_done_s;
    assign drain_done_s = (drain_q == DRN_LAST);
`endif

    // Next-state logic for the scan FSM, divider, counters and address.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        frame_d     = frame_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            ST_IDLE: begin
                div_d       = {DIV_W{1'b0}};
                col_d       = {CNT_W{1'b0}};
                row_d       = {CNT_W{1'b0}};
                addr_d      = {ADDR_W{1'b0}};
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (ce_s) begin
                    div_d = {DIV_W{1'b0}};
                    if (rd_s) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (col_last_s) begin
                        col_d = {CNT_W{1'b0}};
                        if (row_last_s) begin
                            row_d   = {CNT_W{1'b0}};
                            addr_d  = {ADDR_W{1'b0}};
                            frame_d = frame_q + 16'd1;
                            // A stop raised in the eof cycle itself also ends the run.
                            if (continuous && !(stop_pend_q || stop)) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            row_d = row_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DRAIN: begin
`ifdef PIXEL_SCAN_CHECKSUM_EN
                if (drain_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= {DIV_W{1'b0}};
            col_q       <= {CNT_W{1'b0}};
            row_q       <= {CNT_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            frame_q     <= 16'd0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            frame_q     <= frame_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef PIXEL_SCAN_CHECKSUM_EN
    logic [LAT-1:0] rd_pipe_q, sof_pipe_q, eof_pipe_q;
    logic           rd_dl_s, sof_dl_s, eof_dl_s;
    logic [31:0]    sample_s, sum_q, sum_d, cs_q, cs_d;
    logic           csv_q;

    assign rd_dl_s  = rd_pipe_q[LAT-1];
    assign sof_dl_s = sof_pipe_q[LAT-1];
    assign eof_dl_s = eof_pipe_q[LAT-1];
    assign sample_s = {8'h00, RM_data, GM_data, BM_data};

    // Drain cycle counter: runs 0..LAT-1 while in DRAIN.
    always_comb begin
        drain_d = {DRN_W{1'b0}};
        if ((state_q == ST_DRAIN) && !drain_done_s) begin
            drain_d = drain_q + DRN_W'(1);
        end else begin
            drain_d = {DRN_W{1'b0}};
        end
    end

    // Running sum; the first returned pixel of a frame restarts it.
    always_comb begin
        sum_d = sum_q;
        cs_d  = cs_q;
        if (rd_dl_s) begin
            if (sof_dl_s) begin
                sum_d = sample_s;
            end else begin
                sum_d = sum_q + sample_s;
            end
        end else begin
            sum_d = sum_q;
        end
        if (eof_dl_s) begin
            cs_d = sum_d;
        end else begin
            cs_d = cs_q;
        end
    end

    // Return-path delay line, drain counter and checksum registers.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            rd_pipe_q  <= {LAT{1'b0}};
            sof_pipe_q <= {LAT{1'b0}};
            eof_pipe_q <= {LAT{1'b0}};
            drain_q    <= {DRN_W{1'b0}};
            sum_q      <= 32'd0;
            cs_q       <= 32'd0;
            csv_q      <= 1'b0;
        end else begin
            rd_pipe_q[0]  <= rd_s;
            sof_pipe_q[0] <= sof_s;
            eof_pipe_q[0] <= eof_s;
            for (int i = 1; i < LAT; i++) begin
                rd_pipe_q[i]  <= rd_pipe_q[i-1];
                sof_pipe_q[i] <= sof_pipe_q[i-1];
                eof_pipe_q[i] <= eof_pipe_q[i-1];
            end
            drain_q <= drain_d;
            sum_q   <= sum_d;
            cs_q    <= cs_d;
            csv_q   <= eof_dl_s;
        end
    end

    assign checksum       = cs_q;
    assign checksum_valid = csv_q;
`else
    logic unused_rgb_s;
    assign unused_rgb_s   = ^{RM_data, GM_data, BM_data};
    assign checksum       = 32'd0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_scan_engine.sv
// Directed bench for pixel_scan_engine: geometry 4x2 active, 2/1 blanking,
// LAT 2, on two instances (PIX_DIV 2 with blanking, PIX_DIV 1 without).
module tb_pixel_scan_engine;

`ifdef PIXEL_SCAN_CHECKSUM_EN
    localparam int CS_ON = 1;
`else
    localparam int CS_ON = 0;
`endif
    localparam int DRN     = 2 * CS_ON;
    localparam int CS_EXP  = 28 * CS_ON;   // 0+1+...+7 = 0x1C

    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic        rst_n = 1'b0, start = 1'b0, continuous = 1'b0, stop = 1'b0;
    logic        busy, pixel_ce, active, sof, eof, mem_rd, csv;
    logic [11:0] col, row;
    logic [19:0] addr;
    logic [15:0] frame;
    logic [31:0] cs;
    logic [19:0] bd1 = 20'd0, bd2 = 20'd0;

    logic        start1 = 1'b0;
    logic        busy1, ce1, active1, sof1, eof1, rd1, csv1;
    logic [11:0] col1, row1;
    logic [19:0] addr1;
    logic [15:0] frame1;
    logic [31:0] cs1;
    logic [19:0] cd1 = 20'd0, cd2 = 20'd0;

    pixel_scan_engine #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(1),
                        .PIX_DIV(2), .CNT_W(12), .ADDR_W(20), .LAT(2)) dut (
        .clk50(clk50), .rst_n(rst_n), .start(start), .continuous(continuous), .stop(stop),
        .busy(busy), .pixel_ce(pixel_ce), .Pixel_Col_cnt(col), .Pixel_Row_cnt(row),
        .active(active), .sof(sof), .eof(eof), .mem_addr(addr), .mem_rd(mem_rd),
        .frame_cnt(frame), .RM_data(8'd0), .GM_data(8'd0), .BM_data(bd2[7:0]),
        .checksum(cs), .checksum_valid(csv));

    pixel_scan_engine #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(0), .V_BLANK(0),
                        .PIX_DIV(1), .CNT_W(12), .ADDR_W(20), .LAT(2)) dut1 (
        .clk50(clk50), .rst_n(rst_n), .start(start1), .continuous(1'b0), .stop(1'b0),
        .busy(busy1), .pixel_ce(ce1), .Pixel_Col_cnt(col1), .Pixel_Row_cnt(row1),
        .active(active1), .sof(sof1), .eof(eof1), .mem_addr(addr1), .mem_rd(rd1),
        .frame_cnt(frame1), .RM_data(8'd0), .GM_data(8'd0), .BM_data(cd2[7:0]),
        .checksum(cs1), .checksum_valid(csv1));

    // Core model: returned pixel equals the read address, two cycles later.
    always @(posedge clk50) begin
        bd1 <= addr;  bd2 <= bd1;
        cd1 <= addr1; cd2 <= cd1;
    end

    // Monitors sampled on the falling edge.
    int cyc = 0, ce_n = 0, rd_n = 0, busy_n = 0, csv_n = 0, cs_bad = 0, addr_bad = 0;
    int gap_n = 0, gap_bad = 0, last_sof = 0, run_age = 0, first_lat = 0;
    int ce1_n = 0, busy1_n = 0, csv1_n = 0, cs1_bad = 0, eof1_n = 0, eof1_ok = 0;
    logic        busy_prev = 1'b0, have_sof = 1'b0, got_ce = 1'b0, got_rd = 1'b0;
    logic [19:0] exp_addr = 20'd0, first_addr = 20'hFFFFF;

    always @(negedge clk50) begin
        cyc <= cyc + 1;
        busy_prev <= busy;
        if (pixel_ce) ce_n <= ce_n + 1;
        if (busy) busy_n <= busy_n + 1;
        if (csv) begin
            csv_n <= csv_n + 1;
            if (cs !== 32'h0000001C) cs_bad <= cs_bad + 1;
        end
        if (mem_rd) begin
            rd_n <= rd_n + 1;
            if (addr !== (sof ? 20'd0 : exp_addr)) addr_bad <= addr_bad + 1;
            exp_addr <= (sof ? 20'd0 : exp_addr) + 20'd1;
        end
        if (busy && !busy_prev) begin
            have_sof <= 1'b0;
            run_age  <= 1;
            got_ce   <= pixel_ce;
            got_rd   <= mem_rd;
            if (pixel_ce) first_lat <= 1;
            if (mem_rd) first_addr <= addr;
        end else begin
            if (busy && !got_ce) begin
                run_age <= run_age + 1;
                if (pixel_ce) begin got_ce <= 1'b1; first_lat <= run_age + 1; end
            end
            if (busy && !got_rd && mem_rd) begin got_rd <= 1'b1; first_addr <= addr; end
            if (sof) begin
                if (have_sof) begin
                    gap_n <= gap_n + 1;
                    if (cyc - last_sof != 36) gap_bad <= gap_bad + 1;
                end
                have_sof <= 1'b1;
                last_sof <= cyc;
            end
        end
        if (ce1) ce1_n <= ce1_n + 1;
        if (busy1) busy1_n <= busy1_n + 1;
        if (eof1) begin
            eof1_n <= eof1_n + 1;
            if (rd1 && addr1 == 20'd7) eof1_ok <= eof1_ok + 1;
        end
        if (csv1) begin
            csv1_n <= csv1_n + 1;
            if (cs1 !== 32'h0000001C) cs1_bad <= cs1_bad + 1;
        end
    end

    int n_tests = 0, n_fail = 0;
    int b_ce, b_rd, b_busy, b_csv, b_csb, b_ab, b_gap, b_gb, b_frame, k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic snap();
        b_ce = ce_n; b_rd = rd_n; b_busy = busy_n; b_csv = csv_n; b_csb = cs_bad;
        b_ab = addr_bad; b_gap = gap_n; b_gb = gap_bad; b_frame = int'(frame);
    endtask

    task automatic pulse_start();
        tick(1); start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        k = 0;
        while (busy === 1'b1 && k < 500) begin @(negedge clk50); #1; k++; end
        check(tag, {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clk50);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_a"}, {busy, pixel_ce, active, sof, eof, mem_rd, csv, col, row, frame}, 64'd0);
        check({tag, "_b"}, {addr, cs}, 64'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_outs_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Single frame
        snap();
        pulse_start();
        wait_idle("single_timeout");
        check("single_ce", 64'(ce_n - b_ce), 64'd18);
        check("single_rd", 64'(rd_n - b_rd), 64'd8);
        check("single_addr", 64'(addr_bad - b_ab), 64'd0);
        check("single_busy_cyc", 64'(busy_n - b_busy), 64'(36 + DRN));
        check("single_first_ce", 64'(first_lat), 64'd2);
        check("single_first_addr", 64'(first_addr), 64'd0);
        check("single_frame", 64'(frame), 64'(b_frame + 1));
        check("single_csv", 64'(csv_n - b_csv), 64'(CS_ON));
        check("single_cs_val", 64'(cs_bad - b_csb), 64'd0);
        check("single_cs", 64'(cs), 64'(CS_EXP));

        // Continuous, stop raised mid-frame 3
        snap();
        continuous = 1'b1;
        pulse_start();
        k = 0;
        while (int'(frame) != b_frame + 2 && k < 300) begin @(negedge clk50); #1; k++; end
        check("cont_reach_f2", 64'(frame), 64'(b_frame + 2));
        tick(10);
        stop = 1'b1; tick(1); stop = 1'b0;
        wait_idle("cont_timeout");
        continuous = 1'b0;
        check("cont_frame", 64'(frame), 64'(b_frame + 3));
        check("cont_ce", 64'(ce_n - b_ce), 64'd54);
        check("cont_busy_cyc", 64'(busy_n - b_busy), 64'(108 + DRN));
        check("cont_sof_gaps", 64'(gap_n - b_gap), 64'd2);
        check("cont_sof_gap_bad", 64'(gap_bad - b_gb), 64'd0);
        check("cont_csv", 64'(csv_n - b_csv), 64'(3 * CS_ON));
        check("cont_cs_val", 64'(cs_bad - b_csb), 64'd0);

        // Start re-pulsed while busy
        snap();
        pulse_start();
        tick(15);
        start = 1'b1; tick(1); start = 1'b0;
        wait_idle("rebusy_timeout");
        check("rebusy_ce", 64'(ce_n - b_ce), 64'd18);
        check("rebusy_rd", 64'(rd_n - b_rd), 64'd8);
        check("rebusy_busy_cyc", 64'(busy_n - b_busy), 64'(36 + DRN));
        check("rebusy_frame", 64'(frame), 64'(b_frame + 1));
        check("rebusy_idle", {63'd0, busy}, 64'd0);

        // Reset at row 1, column 2
        snap();
        pulse_start();
        k = 0;
        while (!(pixel_ce === 1'b1 && row == 12'd1 && col == 12'd2) && k < 100) begin
            @(negedge clk50); #1; k++;
        end
        check("rst_reach_pos", {col, row}, {12'd2, 12'd1});
        rst_n = 1'b0;
        @(posedge clk50); #1;
        check_outs_zero("midreset");
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check("midreset_no_csv", 64'(csv_n - b_csv), 64'd0);
        snap();
        pulse_start();
        wait_idle("post_rst_timeout");
        check("post_rst_first_addr", 64'(first_addr), 64'd0);
        check("post_rst_rd", 64'(rd_n - b_rd), 64'd8);
        check("post_rst_addr", 64'(addr_bad - b_ab), 64'd0);
        check("post_rst_frame", 64'(frame), 64'd1);
        check("post_rst_csv", 64'(csv_n - b_csv), 64'(CS_ON));
        check("post_rst_cs", 64'(cs), 64'(CS_EXP));

        // PIX_DIV = 1, no blanking
        tick(1); start1 = 1'b1; tick(1); start1 = 1'b0;
        k = 0;
        while (busy1 === 1'b1 && k < 100) begin @(negedge clk50); #1; k++; end
        check("div1_timeout", {63'd0, busy1}, 64'd0);
        repeat (4) @(negedge clk50);
        #1;
        check("div1_ce", 64'(ce1_n), 64'd8);
        check("div1_busy_cyc", 64'(busy1_n), 64'(8 + DRN));
        check("div1_eof", 64'(eof1_n), 64'd1);
        check("div1_eof_rd7", 64'(eof1_ok), 64'd1);
        check("div1_frame", 64'(frame1), 64'd1);
        check("div1_csv", 64'(csv1_n), 64'(CS_ON));
        check("div1_cs_val", 64'(cs1_bad), 64'd0);
        check("div1_cs", 64'(cs1), 64'(CS_EXP));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
